heart_initiator: RTL and testbench
==================================

Name: heart_initiator

Overview:
- Command-driven initiator for the 32x32-bit register memory block.
- Drives that memory's mode, write_enable, address and data_in inputs, and reads its data_out.
- Upstream logic issues single- or multi-beat read/write bursts over a valid/ready command port. Write data arrives on a valid/ready stream; read data leaves on a valid/ready stream.
- Hides the memory's fixed 2-cycle read latency and its write-protect mode from the requester.

Parameters:
- ADDR_W, 5, memory address width; depth is 2**ADDR_W.
- DATA_W, 32, data word width.
- RD_LAT, 2, clock edges from the memory sampling an address to the word being stable on its data_out.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  initiator accepts command; high only in IDLE.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_W  start address.
- cmd_len_m1  in  ADDR_W  burst beats minus one (0 to 31, i.e. 1 to 32 beats).
- wr_valid  in  1  write beat present.
- wr_ready  out  1  write beat accepted.
- wr_data  in  DATA_W  write beat data.
- rd_valid  out  1  read beat present.
- rd_ready  in  1  downstream accepts read beat.
- rd_data  out  DATA_W  read beat data.
- rd_last  out  1  final beat of read burst; qualified by rd_valid.
- busy  out  1  high in any state other than IDLE.
- mem_mode  out  1  to memory mode; 1 = write-protected.
- mem_we  out  1  to memory write_enable.
- mem_addr  out  ADDR_W  to memory address.
- mem_wdata  out  DATA_W  to memory data_in.
- mem_rdata  in  DATA_W  from memory data_out.

Behaviour:
- Reset and reset values:
  - reset is synchronous, active-high; clock is clk.
  - On reset: state = IDLE; cmd_ready = 1; wr_ready = 0; rd_valid = 0; rd_last = 0; rd_data = 0; busy = 0; mem_mode = 1; mem_we = 0; mem_addr = 0; mem_wdata = 0.
  - Reset mid-burst aborts immediately. No further mem_we pulse is issued. Any pending rd_valid is dropped.
- All outputs are registered.
- States: IDLE, WR_BEAT, WR_COMMIT, RD_ISSUE, RD_WAIT, RD_RESP.
- IDLE:
  - cmd_ready = 1. On cmd_valid && cmd_ready, latch start address into addr and cmd_len_m1 into remaining.
  - Go to WR_BEAT if cmd_write = 1, else RD_ISSUE.
  - mem_mode stays 1 whenever no write is being committed.
- WR_BEAT:
  - wr_ready = 1. On wr_valid && wr_ready, register mem_addr = addr, mem_wdata = wr_data, mem_we = 1, mem_mode = 0.
  - Then go to WR_COMMIT; wr_ready drops for that cycle.
- WR_COMMIT:
  - The memory writes on this cycle's edge. Next cycle mem_we = 0 and mem_mode = 1.
  - If remaining = 0, go to IDLE. Otherwise decrement remaining, advance addr, return to WR_BEAT.
  - Maximum throughput is 1 write beat per 2 cycles.
- RD_ISSUE:
  - Register mem_addr = addr, mem_we = 0, mem_mode = 1. Clear the wait counter and go to RD_WAIT.
- RD_WAIT:
  - mem_addr is held constant. Count RD_LAT edges after the first cycle the address is presented.
  - On the edge after that count, capture mem_rdata into rd_data, set rd_valid = 1, and set rd_last = (remaining == 0). Go to RD_RESP.
  - Net read latency, from the first cycle mem_addr shows the new address to rd_valid high, is RD_LAT+1 cycles.
- RD_RESP:
  - rd_valid, rd_data and rd_last are held stable until rd_ready.
  - On handshake: clear rd_valid. If rd_last, go to IDLE; otherwise decrement remaining, advance addr, go to RD_ISSUE.
- Address arithmetic: addr increments modulo 2**ADDR_W, so 31 wraps to 0 within a burst.
- Counters: remaining counts down to 0; a 32-beat burst is cmd_len_m1 = 31.
- Simultaneous events:
  - cmd_valid outside IDLE is ignored; cmd_ready is 0.
  - wr_valid outside WR_BEAT is ignored.
  - rd_ready without rd_valid has no effect.
- mem_we is never high while mem_mode = 1. mem_we and mem_mode change together.

Test Plan:
- Single write then read: cmd write addr 5, len_m1 0, wr_data 0xDEADBEEF, then cmd read addr 5 -> exactly one mem_we pulse with mem_addr 5; rd_data 0xDEADBEEF, rd_last 1, rd_valid RD_LAT+1 cycles after mem_addr = 5.
- Wrapping write burst: write addr 30, len_m1 3, data 0x11, 0x22, 0x33, 0x44 -> mem_we pulses at addresses 30, 31, 0, 1. A read burst of the same range returns the data in order, with rd_last only on the 4th beat.
- Backpressure: read burst len_m1 1, rd_ready held 0 for 5 cycles -> rd_valid and rd_data stable throughout; second beat's mem_addr not issued until the first handshake.
- Write stalls: wr_valid low for 4 cycles mid-burst -> no mem_we pulses during the gap; mem_mode = 1 throughout the gap; burst completes with correct contents.
- Reset mid-burst: reset asserted during the 3rd beat of an 8-beat write -> next cycle state IDLE, mem_we 0, mem_mode 1, cmd_ready 1; locations 3rd beat onward unwritten.
- Full depth: write addr 0, len_m1 31, data = address x 3, then full read -> all 32 words match; busy low only after the final rd handshake.

Source files
------------

// File: rtl/heart_initiator.sv
// heart_initiator
// Command-driven initiator for a 32x32-bit register memory with a fixed read
// latency and a write-protect mode. Upstream logic issues 1..32 beat read or
// write bursts. The memory's read latency and its protect mode are handled
// here, so the requester does not have to deal with them.
//
// Ports
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   cmd_*             : burst command (valid/ready), start address, beats-1
//   wr_valid/ready/data : write beat stream into the initiator
//   rd_valid/ready/data/last : read beat stream out of the initiator
//   busy              : high whenever a burst is in progress
//   mem_mode/we/addr/wdata : registered drive into the memory
//   mem_rdata         : memory data_out
module heart_initiator #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len_m1,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              mem_mode,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Wide enough to hold the value RD_LAT.
    localparam int CNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_BEAT   = 3'd1,
        WR_COMMIT = 3'd2,
        RD_ISSUE  = 3'd3,
        RD_WAIT   = 3'd4,
        RD_RESP   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                wr_ready_q, wr_ready_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_last_q, rd_last_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                busy_q, busy_d;
    logic                mem_mode_q, mem_mode_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    // State and output registers; reset aborts any burst in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= {ADDR_W{1'b0}};
            remaining_q <= {ADDR_W{1'b0}};
            wait_cnt_q  <= {CNT_W{1'b0}};
            cmd_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_data_q   <= {DATA_W{1'b0}};
            busy_q      <= 1'b0;
            mem_mode_q  <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            wait_cnt_q  <= wait_cnt_d;
            cmd_ready_q <= cmd_ready_d;
            wr_ready_q  <= wr_ready_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            rd_data_q   <= rd_data_d;
            busy_q      <= busy_d;
            mem_mode_q  <= mem_mode_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Next-state and next-output logic for the burst sequencer.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        wait_cnt_d  = wait_cnt_q;
        rd_valid_d  = rd_valid_q;
        rd_last_d   = rd_last_q;
        rd_data_d   = rd_data_q;
        mem_mode_d  = mem_mode_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d      = cmd_addr;
                    remaining_d = cmd_len_m1;
                    state_d     = cmd_write ? WR_BEAT : RD_ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_BEAT: begin
                // Write-protect is lifted only for the single commit cycle,
                // and together with mem_we.
                if (wr_valid && wr_ready_q) begin
                    mem_addr_d  = addr_q;
                    mem_wdata_d = wr_data;
                    mem_we_d    = 1'b1;
                    mem_mode_d  = 1'b0;
                    state_d     = WR_COMMIT;
                end else begin
                    state_d = WR_BEAT;
                end
            end
            WR_COMMIT: begin
                mem_we_d   = 1'b0;
                mem_mode_d = 1'b1;
                if (remaining_q == {ADDR_W{1'b0}}) begin
                    state_d = IDLE;
                end else begin
                    remaining_d = remaining_q - ADDR_W'(1);
                    addr_d      = addr_q + ADDR_W'(1);
                    state_d     = WR_BEAT;
                end
            end
            RD_ISSUE: begin
                mem_addr_d = addr_q;
                mem_we_d   = 1'b0;
                mem_mode_d = 1'b1;
                wait_cnt_d = {CNT_W{1'b0}};
                state_d    = RD_WAIT;
            end
            RD_WAIT: begin
                // wait_cnt is 0 on the first cycle the address is visible;
                // the word is captured once RD_LAT further edges have passed.
                if (wait_cnt_q == CNT_W'(RD_LAT)) begin
                    rd_data_d  = mem_rdata;
                    rd_valid_d = 1'b1;
                    rd_last_d  = (remaining_q == {ADDR_W{1'b0}});
                    state_d    = RD_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            RD_RESP: begin
                if (rd_ready && rd_valid_q) begin
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                    if (rd_last_q) begin
                        state_d = IDLE;
                    end else begin
                        remaining_d = remaining_q - ADDR_W'(1);
                        addr_d      = addr_q + ADDR_W'(1);
                        state_d     = RD_ISSUE;
                    end
                end else begin
                    state_d = RD_RESP;
                end
            end
            default: begin
                state_d    = IDLE;
                mem_we_d   = 1'b0;
                mem_mode_d = 1'b1;
                rd_valid_d = 1'b0;
            end
        endcase

        // Handshake/status outputs are registered from the upcoming state
        // so they line up with the state they describe.
        cmd_ready_d = (state_d == IDLE);
        wr_ready_d  = (state_d == WR_BEAT);
        busy_d      = (state_d != IDLE);
    end

    assign cmd_ready = cmd_ready_q;
    assign wr_ready  = wr_ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign rd_data   = rd_data_q;
    assign busy      = busy_q;
    assign mem_mode  = mem_mode_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_heart_initiator.sv
// Testbench for heart_initiator: a behavioural 32x32 memory with two-stage
// read pipeline, a shadow array holding the expected memory contents, and a
// list of expected write pulses. Directed scenarios plus randomized bursts.
module tb_heart_initiator;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic          clk;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_len_m1;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          busy;
    logic          mem_mode;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int tests  = 0;
    int failed = 0;
    int viol   = 0;

    logic [DW-1:0]   ref_mem [32];
    logic [DW-1:0]   mem_arr [32];
    logic [DW-1:0]   wdata_buf [32];
    logic [AW-1:0]   addr_r1;
    logic            load_mem;
    logic [AW+DW-1:0] act_pulses [$];
    logic [AW+DW-1:0] exp_pulses [$];

    heart_initiator #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len_m1(cmd_len_m1),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy), .mem_mode(mem_mode), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: writes only when unprotected; address sampled, then data out one edge later.
    always @(posedge clk) begin
        if (load_mem) begin
            for (int k = 0; k < 32; k++) mem_arr[k] <= ref_mem[k];
        end else if (mem_we === 1'b1 && mem_mode === 1'b0) begin
            mem_arr[mem_addr] <= mem_wdata;
        end
        addr_r1   <= mem_addr;
        mem_rdata <= mem_arr[addr_r1];
    end

    // Records every write pulse and any cycle with mem_we high while protected.
    always @(posedge clk) begin
        if (mem_we === 1'b1) act_pulses.push_back({mem_addr, mem_wdata});
        if (mem_we === 1'b1 && mem_mode === 1'b1) viol <= viol + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input logic wr, input int a, input int l);
        logic hs;
        int n;
        n = 0;
        cmd_valid  = 1'b1;
        cmd_write  = wr;
        cmd_addr   = AW'(a);
        cmd_len_m1 = AW'(l);
        do begin
            hs = cmd_ready;
            tick();
            n++;
        end while (!hs && n < 100);
        cmd_valid = 1'b0;
        if (!hs) check("cmd_timeout", 64'd0, 64'd1);
    endtask

    task automatic write_beat(input logic [DW-1:0] d);
        logic hs;
        int n;
        n = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        do begin
            hs = wr_ready;
            tick();
            n++;
        end while (!hs && n < 100);
        wr_valid = 1'b0;
        if (!hs) check("wr_timeout", 64'd0, 64'd1);
    endtask

    task automatic compare_pulses(input string tag);
        int n;
        check({tag, "_pulse_count"}, act_pulses.size(), exp_pulses.size());
        n = (act_pulses.size() < exp_pulses.size()) ? act_pulses.size() : exp_pulses.size();
        for (int i = 0; i < n; i++) check({tag, "_pulse"}, act_pulses[i], exp_pulses[i]);
        act_pulses.delete();
        exp_pulses.delete();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("idle_timeout", 64'd0, 64'd1);
    endtask

    // Write burst with wr_valid gaps of gmin..gmax cycles between beats.
    task automatic do_write(input string tag, input int a, input int l, input int gmin, input int gmax);
        logic [AW-1:0] ea;
        int g;
        issue_cmd(1'b1, a, l);
        for (int i = 0; i <= l; i++) begin
            if (i > 0) begin
                g = $urandom_range(gmax, gmin);
                for (int j = 0; j < g; j++) begin
                    tick();
                    check({tag, "_gap_we"}, mem_we, 1'b0);
                    check({tag, "_gap_mode"}, mem_mode, 1'b1);
                end
            end
            write_beat(wdata_buf[i]);
            ea = AW'(a + i);
            ref_mem[ea] = wdata_buf[i];
            exp_pulses.push_back({ea, wdata_buf[i]});
        end
        wait_idle();
        compare_pulses(tag);
    endtask

    // Read burst with rd_ready held low for bmin..bmax cycles on each beat.
    task automatic do_read(input string tag, input int a, input int l, input int bmin, input int bmax);
        logic [AW-1:0] ea;
        int n;
        int bp;
        issue_cmd(1'b0, a, l);
        for (int i = 0; i <= l; i++) begin
            ea = AW'(a + i);
            n = 0;
            while (rd_valid !== 1'b1 && n < 50) begin
                tick();
                n++;
            end
            check({tag, "_latency"}, n, LAT + 2);
            check({tag, "_data"}, rd_data, ref_mem[ea]);
            check({tag, "_last"}, rd_last, (i == l));
            check({tag, "_busy"}, busy, 1'b1);
            check({tag, "_cmd_ready"}, cmd_ready, 1'b0);
            check({tag, "_mem_addr"}, mem_addr, ea);
            bp = $urandom_range(bmax, bmin);
            for (int j = 0; j < bp; j++) begin
                tick();
                check({tag, "_hold_valid"}, rd_valid, 1'b1);
                check({tag, "_hold_data"}, rd_data, ref_mem[ea]);
                check({tag, "_hold_last"}, rd_last, (i == l));
                check({tag, "_hold_addr"}, mem_addr, ea);
            end
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
        check({tag, "_end_busy"}, busy, 1'b0);
        check({tag, "_end_valid"}, rd_valid, 1'b0);
    endtask

    initial begin
        int a;
        int l;
        reset = 1'b1; load_mem = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len_m1 = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        for (int k = 0; k < 32; k++) ref_mem[k] = $urandom();

        // Reset values
        repeat (3) tick();
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_wr_ready", wr_ready, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_last", rd_last, 1'b0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_mem_mode", mem_mode, 1'b1);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 5'd0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0; load_mem = 1'b0;
        act_pulses.delete();
        tick();

        // Single write then read
        wdata_buf[0] = 32'hDEADBEEF;
        do_write("single_wr", 5, 0, 0, 0);
        do_read("single_rd", 5, 0, 0, 0);

        // Wrapping burst 30,31,0,1
        wdata_buf[0] = 32'h11; wdata_buf[1] = 32'h22;
        wdata_buf[2] = 32'h33; wdata_buf[3] = 32'h44;
        do_write("wrap_wr", 30, 3, 0, 0);
        do_read("wrap_rd", 30, 3, 0, 0);

        // Backpressure: 5 cycles of rd_ready low per beat
        do_read("bp_rd", 30, 1, 5, 5);

        // Write stalls of 4 cycles
        for (int i = 0; i < 4; i++) wdata_buf[i] = $urandom();
        do_write("stall_wr", 10, 3, 4, 4);
        do_read("stall_rd", 10, 3, 0, 1);

        // Reset during the 3rd beat of an 8-beat write
        issue_cmd(1'b1, 16, 7);
        for (int i = 0; i < 2; i++) begin
            wdata_buf[i] = $urandom();
            write_beat(wdata_buf[i]);
            ref_mem[16 + i] = wdata_buf[i];
            exp_pulses.push_back({AW'(16 + i), wdata_buf[i]});
        end
        tick();
        wr_valid = 1'b1; wr_data = 32'hBAD0BAD0; reset = 1'b1;
        tick();
        reset = 1'b0; wr_valid = 1'b0;
        check("rstmid_cmd_ready", cmd_ready, 1'b1);
        check("rstmid_mem_we", mem_we, 1'b0);
        check("rstmid_mem_mode", mem_mode, 1'b1);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_wr_ready", wr_ready, 1'b0);
        repeat (3) tick();
        compare_pulses("rstmid");
        do_read("rstmid_rd", 16, 7, 0, 0);

        // Full depth
        for (int i = 0; i < 32; i++) wdata_buf[i] = i * 3;
        do_write("full_wr", 0, 31, 0, 0);
        do_read("full_rd", 0, 31, 0, 0);

        // Randomized bursts
        for (int it = 0; it < 8; it++) begin
            a = $urandom_range(31, 0);
            l = $urandom_range(7, 0);
            for (int i = 0; i <= l; i++) wdata_buf[i] = $urandom();
            do_write("rnd_wr", a, l, 0, 2);
            do_read("rnd_rd", $urandom_range(31, 0), $urandom_range(5, 0), 0, 2);
        end

        tick();
        check("we_while_protected", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
